// File: rtl/trace_duel_controller.sv
// Round sequencer for the wand-trace game: walks the pattern ROM, arbitrates
// round wins between two players, tracks scores and per-round timeouts.
module trace_duel_controller #(
   parameter int unsigned NUM_ROUNDS     = 20,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        two_player_mode,
   input  logic [15:0] p1_traced,
   input  logic [15:0] p2_traced,
   input  logic [15:0] pattern,
   output logic [5:0]  pattern_idx,
   output logic        trace_screen_on,
   output logic [5:0]  p1_score,
   output logic [5:0]  p2_score,
   output logic        round_done,
   output logic [1:0]  round_winner,
   output logic        timeout,
   output logic        game_over,
   output logic [1:0]  winner
);

   localparam int unsigned IDX_W   = 6;
   localparam int unsigned SCORE_W = 6;
   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_ROUNDS - 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [SCORE_W-1:0]   p1_score_q, p1_score_d;
   logic [SCORE_W-1:0]   p2_score_q, p2_score_d;
   logic [1:0]           round_winner_q, round_winner_d;
   logic                 round_done_q, round_done_d;
   logic                 timeout_q, timeout_d;
   logic                 screen_q, screen_d;
   logic                 game_over_q, game_over_d;
   logic [1:0]           winner_q, winner_d;
   logic                 prio_p2_q, prio_p2_d;

   logic m1, m2, p2_wins, released;

   assign m1       = ((p1_traced & pattern) == pattern);
   assign m2       = two_player_mode && ((p2_traced & pattern) == pattern);
   // On a tie the priority holder wins; otherwise whoever matched alone.
   assign p2_wins  = m2 && (!m1 || prio_p2_q);
   assign released = (p1_traced == 16'h0000) &&
                     ((p2_traced == 16'h0000) || !two_player_mode);

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      idx_d          = idx_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      round_winner_d = round_winner_q;
      round_done_d   = 1'b0;
      timeout_d      = 1'b0;
      prio_p2_d      = prio_p2_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               p1_score_d     = '0;
               p2_score_d     = '0;
               round_winner_d = 2'b00;
               idx_d          = '0;
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            timer_d = '0;
            state_d = S_PLAY;
         end
         S_PLAY: begin
            if (m1 || m2) begin
               if (m1 && m2) prio_p2_d = !prio_p2_q;
               if (p2_wins) begin
                  p2_score_d     = p2_score_q + SCORE_W'(1);
                  round_winner_d = 2'b10;
               end else begin
                  p1_score_d     = p1_score_q + SCORE_W'(1);
                  round_winner_d = 2'b01;
               end
               round_done_d = 1'b1;
               state_d      = S_RELEASE;
            end else if (timer_q == TIMER_LAST) begin
               timeout_d      = 1'b1;
               round_winner_d = 2'b00;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_RELEASE: begin
            if (released) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      screen_d    = (state_d == S_PLAY);
      game_over_d = (state_d == S_DONE);
      winner_d    = 2'b00;
      if (game_over_d) begin
         if (p1_score_d > p2_score_d)      winner_d = 2'b01;
         else if (p2_score_d > p1_score_d) winner_d = 2'b10;
         else                              winner_d = 2'b11;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         idx_q          <= '0;
         p1_score_q     <= '0;
         p2_score_q     <= '0;
         round_winner_q <= 2'b00;
         round_done_q   <= 1'b0;
         timeout_q      <= 1'b0;
         screen_q       <= 1'b0;
         game_over_q    <= 1'b0;
         winner_q       <= 2'b00;
         prio_p2_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         idx_q          <= idx_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         round_winner_q <= round_winner_d;
         round_done_q   <= round_done_d;
         timeout_q      <= timeout_d;
         screen_q       <= screen_d;
         game_over_q    <= game_over_d;
         winner_q       <= winner_d;
         prio_p2_q      <= prio_p2_d;
      end
   end

   assign pattern_idx     = idx_q;
   assign trace_screen_on = screen_q;
   assign p1_score        = p1_score_q;
   assign p2_score        = p2_score_q;
   assign round_done      = round_done_q;
   assign round_winner    = round_winner_q;
   assign timeout         = timeout_q;
   assign game_over       = game_over_q;
   assign winner          = winner_q;

endmodule

// File: doc/trace_duel_controller.md
# trace_duel_controller

Round sequencer for the wand-trace game. It steps a pattern index through the trace pattern ROM and gates the trace screen on and off. It decides which player wins each round, including arbitration when both players complete the same trace in the same cycle. It keeps per-player scores, enforces a per-round timeout, and declares the game winner after a fixed number of rounds.

## Interface
Parameters:
- NUM_ROUNDS, 20: rounds per game; legal range 1–63.
- TIMEOUT_CYCLES, 50_000_000: PLAY cycles allowed before the round is forfeited; minimum 2.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begins a game; honoured only in IDLE or DONE.
- two_player_mode, input, 1: when 0, p2_traced is ignored everywhere.
- p1_traced, input, 16: player 1 traced-cell mask.
- p2_traced, input, 16: player 2 traced-cell mask.
- pattern, input, 16: ROM output for the current pattern_idx; combinational, valid one cycle after an index change.
- pattern_idx, output, 6: current ROM address.
- trace_screen_on, output, 1: high only in PLAY.
- p1_score, output, 6: rounds won by player 1.
- p2_score, output, 6: rounds won by player 2.
- round_done, output, 1: one-cycle pulse when a round is won.
- round_winner, output, 2: winner of the most recent round (01 = P1, 10 = P2, 00 = timeout or none); held between rounds.
- timeout, output, 1: one-cycle pulse when a round is forfeited.
- game_over, output, 1: high in DONE.
- winner, output, 2: 01 = P1, 10 = P2, 11 = tie; 00 unless game_over.

## Operation
States are IDLE, LOAD, PLAY, RELEASE and DONE.

**Reset.** State goes to IDLE. All outputs reset to 0. The timer clears and the tie-priority flag selects P1.

**IDLE.** On start, clear both scores and round_winner, set pattern_idx = 0, and go to LOAD.

**LOAD.** Lasts one cycle to let the ROM settle. Clear the timer and go to PLAY.

**PLAY.** Each cycle, evaluate matches:
- m1 = ((p1_traced & pattern) == pattern).
- m2 = two_player_mode & ((p2_traced & pattern) == pattern).
- An all-zero pattern therefore matches immediately.

Resolve the cycle as follows:
- **Only m1:** P1 wins the round.
- **Only m2:** P2 wins the round.
- **Both:** the player holding tie priority wins, and priority then passes to the other player. Priority changes only on ties.
- **Any win:** increment the winner's score, pulse round_done, set round_winner, and go to RELEASE.
- **No match and timer == TIMEOUT_CYCLES-1:** pulse timeout and set round_winner = 00.
  - If pattern_idx == NUM_ROUNDS-1, go to DONE.
  - Otherwise increment pattern_idx and go to LOAD.
- **Otherwise:** increment the timer.
- A match takes precedence over a timeout in the same cycle.

**RELEASE.** Waits until p1_traced == 0 and (p2_traced == 0 or !two_player_mode). This prevents a held trace from scoring on the next pattern. Once released:
- If pattern_idx == NUM_ROUNDS-1, go to DONE.
- Otherwise increment pattern_idx and go to LOAD.
- There is no timeout in RELEASE.

**DONE.** game_over = 1. winner is computed from the scores and held. On start, behave exactly as IDLE does on start.

**Other rules:**
- start is ignored in LOAD, PLAY and RELEASE.
- Scores never exceed NUM_ROUNDS, so they do not wrap.
- A mid-game change of two_player_mode takes effect on the next PLAY cycle.

## Timing
- start sampled at edge t: LOAD at t+1, PLAY and trace_screen_on = 1 at t+2.
- Match sampled at edge t: round_done, score and round_winner update at t+1; trace_screen_on = 0 at t+1.
- Release sampled at edge t: LOAD at t+1 with the new pattern_idx, PLAY at t+2.
- Timeout: if PLAY is entered at cycle p, timeout pulses at p+TIMEOUT_CYCLES.
- Minimum round length is 3 cycles: LOAD, PLAY with an immediate match, and RELEASE with inputs already clear.
- reset asserted in any state: all outputs are at reset values on the next edge, and any pending pulse is suppressed.

## Test plan
- **Single-player round.** Setup: two_player_mode = 0, pattern = 16'h0231, p1_traced = 16'h0233 in PLAY. Required: round_done pulse, p1_score = 1, round_winner = 01. While p1_traced is held, the block stays in RELEASE. Clearing p1_traced gives LOAD with pattern_idx = 1.
- **Tie arbitration.** Setup: two_player_mode = 1, both players match in the same cycle on three successive rounds. Required: winners P1, then P2, then P1; final scores p1 = 2, p2 = 1.
- **Timeout.** Setup: TIMEOUT_CYCLES = 4, no match. Required: timeout pulses 4 cycles after PLAY entry, both scores unchanged, round_winner = 00, pattern_idx increments.
- **Player 2 ignored in single-player mode.** Setup: two_player_mode = 0, p2_traced = 16'hFFFF. Required: P2 never scores, and RELEASE ignores p2_traced.
- **Game end.** Setup: NUM_ROUNDS = 3, P1 wins 2 rounds and P2 wins 1. Required: game_over = 1, winner = 01. A fresh start clears the scores and goes to LOAD with pattern_idx = 0.
- **Reset mid-game.** Setup: assert reset during PLAY with p2_score = 3. Required: next edge gives IDLE with all outputs 0, and tie priority returns to P1.
